instr_sequencer: RTL and testbench
==================================

# instr_sequencer

Multi-cycle control FSM that sequences the fetch/decode datapath (PC register, instruction ROM, field decoder) for the RV32I subset used by our programs. It owns the PC and latches the fetched instruction. It computes the next PC for sequential, branch and jump flow, and emits per-phase enables for the register file, ALU operand mux and data memory. It replaces the free-running +4 PC loop and sits between the instruction ROM and the execute datapath.

## Interface
Parameters:
- ADDR_W, 8: PC / instruction-address width.
- RESET_PC, 0: PC value loaded on reset.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- run  in  1  advance enable, sampled only in FETCH.
- instr  in  32  ROM output for address pc (combinational).
- br_taken  in  1  branch comparator result, valid in EXEC.
- rs1_val  in  ADDR_W  low bits of rs1 register value (JALR base).
- mem_ack  in  1  data memory completion, sampled in MEM.
- pc  out  ADDR_W  current instruction address.
- ir  out  32  latched instruction.
- state  out  3  current FSM state encoding.
- alu_imm  out  1  ALU B-operand selects immediate (OP_IMM, LOAD, STORE, JALR).
- mem_re  out  1  load request, high throughout MEM for LOAD.
- mem_we  out  1  store request, high throughout MEM for STORE.
- reg_we  out  1  register write pulse, high only in WB.
- retire  out  1  one-cycle pulse when an instruction completes.
- halt  out  1  sticky fault flag.

## Operation
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5.
- FETCH, run=1: ir<=instr, go to DECODE. FETCH, run=0: hold, no outputs.
- DECODE: classify ir[6:0].
  - 32'h0 is NOP: npc=pc+4, retire, go to FETCH.
  - Opcode not in {0010011, 0110011, 0000011, 0100011, 1100011, 1101111, 1100111}: go to HALT.
  - Otherwise go to EXEC.
- EXEC:
  - Computes internal npc.
  - BRANCH: npc = br_taken ? pc+immB : pc+4; retire; go to FETCH.
  - LOAD/STORE: npc=pc+4; go to MEM.
  - JAL: npc=pc+immJ. JALR: npc=(rs1_val+immI)&~1. OP/OP_IMM: npc=pc+4. All three go to WB.
- MEM: holds mem_re/mem_we until mem_ack=1. On ack, LOAD goes to WB; STORE retires and goes to FETCH.
- WB: reg_we=1, retire, go to FETCH.
- pc<=npc only on the retire cycle. pc therefore holds the instruction's own address through WB, so the datapath can form the link value as pc+4.
- Arithmetic: immediates are sign-extended, then truncated to ADDR_W. PC sums wrap modulo 2^ADDR_W.
- Misaligned target (npc[1:0]!=0) detected at retire: pc is not updated, go to HALT.
- HALT: halt=1, all enables 0, pc and ir frozen. Only rst exits.

## Timing
- Reset values: pc=RESET_PC, ir=0, state=FETCH; alu_imm, mem_re, mem_we, reg_we, retire and halt all 0.
- Cycles per instruction, run=1, mem_ack immediate:
  - NOP: 2.
  - BRANCH: 3.
  - OP, OP_IMM, JAL, JALR: 4.
  - STORE: 4.
  - LOAD: 5.
  - Each mem_ack wait cycle adds 1.
- mem_re/mem_we rise on the cycle after EXEC. They fall on the cycle after mem_ack is sampled high.
- retire coincides with the pc update edge. The next FETCH presents the new pc to the ROM.
- rst overrides every state, including MEM with a request pending and HALT. Outputs are at reset values one cycle later.
- run deasserted outside FETCH has no effect; the current instruction completes.
- mem_ack outside MEM is ignored.

## Structure
- Shared package seq_pkg: opcode constants, state enum, default ADDR_W and RESET_PC.
- One sub-module, imm_gen: combinational extraction of immI, immS, immB and immJ from ir.
- The FSM, npc logic and output decode live in instr_sequencer.

## Test plan
- Reset, then 32'h00000000 at pc 0 -> retire after 2 cycles, pc=4, reg_we never asserted.
- 32'h00450693 (addi) at pc 4 -> alu_imm=1 in EXEC; reg_we pulse in WB on cycle 4; pc=8.
- 32'h00b76463 (bltu, +8) at pc 0x0c:
  - br_taken=1 -> pc=0x14 after 3 cycles.
  - br_taken=0 -> pc=0x10.
- 32'h0006a803 (lw) with mem_ack delayed 3 cycles -> mem_re high 4 cycles, then WB; pc advances by 4; total 8 cycles.
- 32'hfc1ff06f (jal -64) at pc 0x4c -> pc=0x0c.
- Edge cases:
  - JALR with rs1_val=0xFE, imm 4 -> pc wraps to 0x02, misaligned, so halt=1 and pc stays.
  - Illegal opcode 32'hFFFFFFFF -> halt=1.
  - rst during MEM -> mem_re=0 and state=FETCH next cycle.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared definitions for the instruction sequencer: FSM state encoding, RV32I
// opcode constants used for classification, and default parameter values.
package seq_pkg;

  localparam int unsigned DefAddrW   = 8;
  localparam int unsigned DefResetPc = 0;

  typedef enum logic [2:0] {
    StFetch  = 3'd0,
    StDecode = 3'd1,
    StExec   = 3'd2,
    StMem    = 3'd3,
    StWb     = 3'd4,
    StHalt   = 3'd5
  } state_e;

  localparam logic [6:0] OpcOpImm  = 7'b0010011;
  localparam logic [6:0] OpcOp     = 7'b0110011;
  localparam logic [6:0] OpcLoad   = 7'b0000011;
  localparam logic [6:0] OpcStore  = 7'b0100011;
  localparam logic [6:0] OpcBranch = 7'b1100011;
  localparam logic [6:0] OpcJal    = 7'b1101111;
  localparam logic [6:0] OpcJalr   = 7'b1100111;

  function automatic logic is_legal_opc(input logic [6:0] opc);
    return opc inside {OpcOpImm, OpcOp, OpcLoad, OpcStore, OpcBranch, OpcJal, OpcJalr};
  endfunction

  // Classes whose ALU B operand is the immediate rather than rs2.
  function automatic logic uses_imm(input logic [6:0] opc);
    return opc inside {OpcOpImm, OpcLoad, OpcStore, OpcJalr};
  endfunction

endpackage

// File: rtl/imm_gen.sv
// Immediate extraction for the sequencer.
// Builds the sign-extended I, S, B and J immediates from the latched
// instruction and returns the one matching its opcode, truncated to ADDR_W.
//   ir  : latched instruction word
//   imm : format-selected immediate, ADDR_W bits (wraps like the PC)
module imm_gen
  import seq_pkg::*;
#(
  parameter int unsigned ADDR_W = DefAddrW
) (
  input  logic [31:0]       ir,
  output logic [ADDR_W-1:0] imm
);

  logic [31:0] imm_i, imm_s, imm_b, imm_j, imm_full;

  always_comb begin
    imm_i = {{20{ir[31]}}, ir[31:20]};
    imm_s = {{20{ir[31]}}, ir[31:25], ir[11:7]};
    imm_b = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
    imm_j = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
  end

  always_comb begin
    case (ir[6:0])
      OpcStore:  imm_full = imm_s;
      OpcBranch: imm_full = imm_b;
      OpcJal:    imm_full = imm_j;
      default:   imm_full = imm_i;
    endcase
  end

  assign imm = ADDR_W'(imm_full);

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle fetch/decode/execute sequencer for the RV32I subset.
// Owns the PC, latches the fetched instruction, computes next-PC for
// sequential, branch and jump flow, and emits per-phase datapath enables.
//   clk, rst   : clock, synchronous active-high reset
//   run        : advance enable, only looked at in FETCH
//   instr      : ROM data for address pc
//   br_taken   : branch comparator result (EXEC)
//   rs1_val    : low bits of rs1 (JALR base)
//   mem_ack    : data memory completion (MEM)
//   pc, ir     : current instruction address / latched instruction
//   state      : FSM state encoding
//   alu_imm    : ALU B operand selects immediate
//   mem_re/we  : load/store request held through MEM
//   reg_we     : register write in WB
//   retire     : instruction completes; pc updates on this edge
//   halt       : sticky fault flag
module instr_sequencer
  import seq_pkg::*;
#(
  parameter int unsigned       ADDR_W   = DefAddrW,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DefResetPc)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic [31:0]       instr,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] rs1_val,
  input  logic              mem_ack,
  output logic [ADDR_W-1:0] pc,
  output logic [31:0]       ir,
  output logic [2:0]        state,
  output logic              alu_imm,
  output logic              mem_re,
  output logic              mem_we,
  output logic              reg_we,
  output logic              retire,
  output logic              halt
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] npc_q, npc_d;
  logic [31:0]       ir_q, ir_d;

  logic [ADDR_W-1:0] imm, pc_plus4, jalr_sum, exec_npc, tgt;
  logic [6:0]        opc;
  logic              is_load, is_store, retire_req;

  imm_gen #(
    .ADDR_W(ADDR_W)
  ) u_imm_gen (
    .ir (ir_q),
    .imm(imm)
  );

  assign opc      = ir_q[6:0];
  assign is_load  = (opc == OpcLoad);
  assign is_store = (opc == OpcStore);
  assign pc_plus4 = pc_q + ADDR_W'(4);
  assign jalr_sum = rs1_val + imm;

  always_comb begin
    case (opc)
      OpcBranch: exec_npc = br_taken ? (pc_q + imm) : pc_plus4;
      OpcJal:    exec_npc = pc_q + imm;
      OpcJalr:   exec_npc = jalr_sum & ~ADDR_W'(1);
      default:   exec_npc = pc_plus4;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    npc_d      = npc_q;
    ir_d       = ir_q;
    tgt        = npc_q;
    retire_req = 1'b0;
    mem_re     = 1'b0;
    mem_we     = 1'b0;
    reg_we     = 1'b0;
    retire     = 1'b0;
    halt       = 1'b0;
    alu_imm    = 1'b0;

    case (state_q)
      StFetch: begin
        if (run) begin
          ir_d    = instr;
          state_d = StDecode;
        end
      end
      StDecode: begin
        if (ir_q == 32'h0) begin
          tgt        = pc_plus4;
          retire_req = 1'b1;
          state_d    = StFetch;
        end else if (!is_legal_opc(opc)) begin
          state_d = StHalt;
        end else begin
          state_d = StExec;
        end
      end
      StExec: begin
        alu_imm = uses_imm(opc);
        npc_d   = exec_npc;
        tgt     = exec_npc;
        if (opc == OpcBranch) begin
          retire_req = 1'b1;
          state_d    = StFetch;
        end else if (is_load || is_store) begin
          state_d = StMem;
        end else begin
          state_d = StWb;
        end
      end
      StMem: begin
        alu_imm = uses_imm(opc);
        mem_re  = is_load;
        mem_we  = is_store;
        if (mem_ack) begin
          if (is_load) begin
            state_d = StWb;
          end else begin
            retire_req = 1'b1;
            state_d    = StFetch;
          end
        end
      end
      StWb: begin
        alu_imm    = uses_imm(opc);
        reg_we     = 1'b1;
        retire_req = 1'b1;
        state_d    = StFetch;
      end
      StHalt: begin
        halt = 1'b1;
      end
      default: begin
        state_d = StHalt;
      end
    endcase

    // A misaligned target faults instead of retiring; pc keeps the faulting address.
    if (retire_req) begin
      if (tgt[1:0] != 2'b00) begin
        state_d = StHalt;
      end else begin
        pc_d   = tgt;
        retire = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StFetch;
      pc_q    <= RESET_PC;
      npc_q   <= RESET_PC;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      npc_q   <= npc_d;
      ir_q    <= ir_d;
    end
  end

  assign pc    = pc_q;
  assign ir    = ir_q;
  assign state = state_q;

endmodule

// File: tb/tb_instr_sequencer.sv
module tb_instr_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        run = 1'b0;
  logic [31:0] instr = 32'h0;
  logic        br_taken = 1'b0;
  logic [7:0]  rs1_val = 8'h0;
  logic        mem_ack = 1'b0;
  logic [7:0]  pc;
  logic [31:0] ir;
  logic [2:0]  state;
  logic        alu_imm, mem_re, mem_we, reg_we, retire, halt;

  int n_pass = 0;
  int n_tot  = 0;

  instr_sequencer #(
    .ADDR_W  (8),
    .RESET_PC(8'h00)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .run     (run),
    .instr   (instr),
    .br_taken(br_taken),
    .rs1_val (rs1_val),
    .mem_ack (mem_ack),
    .pc      (pc),
    .ir      (ir),
    .state   (state),
    .alu_imm (alu_imm),
    .mem_re  (mem_re),
    .mem_we  (mem_we),
    .reg_we  (reg_we),
    .retire  (retire),
    .halt    (halt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] npc;
    int         cyc;
    int         re;
    int         we;
    int         rwe;
    bit         aimm;
    bit         hlt;
  } exp_t;

  typedef struct {
    bit          do_rst;
    logic [31:0] w;
    bit          bt;
    logic [7:0]  rs1;
    int          dly;
    logic [7:0]  e_pc;
    int          e_cyc;
    bit          e_hlt;
    int          e_rwe;
    int          e_re;
    int          e_we;
    bit          e_aimm;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic bit legal_opc(input logic [6:0] o);
    return o == 7'b0010011 || o == 7'b0110011 || o == 7'b0000011 || o == 7'b0100011 ||
           o == 7'b1100011 || o == 7'b1101111 || o == 7'b1100111;
  endfunction

  // Instruction-level outcome from the architectural rules.
  function automatic exp_t model(input logic [7:0] pcv, input logic [31:0] w, input bit bt,
                                 input logic [7:0] rs1, input int dly);
    exp_t e;
    int tgt;
    logic signed [11:0] ii;
    logic signed [12:0] ib;
    logic signed [20:0] ij;
    e  = '{npc: pcv, cyc: 0, re: 0, we: 0, rwe: 0, aimm: 1'b0, hlt: 1'b0};
    ii = w[31:20];
    ib = {w[31], w[7], w[30:25], w[11:8], 1'b0};
    ij = {w[31], w[19:12], w[20], w[30:21], 1'b0};
    tgt = int'(pcv) + 4;
    if (w == 32'h0) e.cyc = 2;
    else begin
      case (w[6:0])
        7'b1100011: begin e.cyc = 3; if (bt) tgt = int'(pcv) + int'(ib); end
        7'b0000011: begin e.cyc = 5 + dly; e.re = 1 + dly; e.rwe = 1; e.aimm = 1; end
        7'b0100011: begin e.cyc = 4 + dly; e.we = 1 + dly; e.aimm = 1; end
        7'b1101111: begin e.cyc = 4; e.rwe = 1; tgt = int'(pcv) + int'(ij); end
        7'b1100111: begin e.cyc = 4; e.rwe = 1; e.aimm = 1; tgt = (int'(rs1) + int'(ii)) & ~1; end
        7'b0010011: begin e.cyc = 4; e.rwe = 1; e.aimm = 1; end
        7'b0110011: begin e.cyc = 4; e.rwe = 1; end
        default:    e.hlt = 1'b1;
      endcase
    end
    tgt = tgt & 255;
    if (!e.hlt) begin
      if ((tgt & 3) != 0) e.hlt = 1'b1;
      else e.npc = 8'(tgt);
    end
    return e;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Runs one instruction starting at a negedge in FETCH; observes until retire or halt.
  task automatic exec_one(input logic [31:0] w, input bit bt, input logic [7:0] rs1,
                          input int dly, input bit noisy, output exp_t o);
    int mw;
    bit done;
    o  = '{npc: 8'h0, cyc: 0, re: 0, we: 0, rwe: 0, aimm: 1'b0, hlt: 1'b0};
    mw = 0;
    done = 1'b0;
    instr = w;
    br_taken = bt;
    rs1_val = rs1;
    for (int k = 0; k < 64 && !done; k++) begin
      if (state == 3'd3) begin
        mem_ack = (mw >= dly);
        mw++;
      end else begin
        mem_ack = noisy ? 1'($urandom) : 1'b0;
      end
      run = (state == 3'd0) ? 1'b1 : (noisy ? 1'($urandom) : 1'b1);
      #1;
      if (halt) begin
        o.hlt = 1'b1;
        done = 1'b1;
      end else begin
        o.cyc++;
        if (mem_re) o.re++;
        if (mem_we) o.we++;
        if (reg_we) o.rwe++;
        if (state == 3'd2 && alu_imm) o.aimm = 1'b1;
        if (retire) done = 1'b1;
        @(negedge clk);
      end
    end
    chk("completion_bound", 32'(done), 32'd1);
    mem_ack = 1'b0;
    o.npc = pc;
  endtask

  vec_t tbl[13];

  initial begin
    exp_t o, e;
    logic [7:0] exp_pc;
    logic [31:0] w;
    bit bt;
    logic [7:0] rs1;
    int dly;

    // do_rst, word, bt, rs1, dly, e_pc, e_cyc, e_hlt, e_rwe, e_re, e_we, e_aimm
    tbl[0]  = '{1'b1, 32'h00000000, 1'b0, 8'h00, 0, 8'h04, 2, 1'b0, 0, 0, 0, 1'b0};
    tbl[1]  = '{1'b0, 32'h00450693, 1'b0, 8'h00, 0, 8'h08, 4, 1'b0, 1, 0, 0, 1'b1};
    tbl[2]  = '{1'b0, 32'h00450693, 1'b0, 8'h00, 0, 8'h0c, 4, 1'b0, 1, 0, 0, 1'b1};
    tbl[3]  = '{1'b0, 32'h00b76463, 1'b1, 8'h00, 0, 8'h14, 3, 1'b0, 0, 0, 0, 1'b0};
    tbl[4]  = '{1'b0, 32'h0380006f, 1'b0, 8'h00, 0, 8'h4c, 4, 1'b0, 1, 0, 0, 1'b0};
    tbl[5]  = '{1'b0, 32'hfc1ff06f, 1'b0, 8'h00, 0, 8'h0c, 4, 1'b0, 1, 0, 0, 1'b0};
    tbl[6]  = '{1'b0, 32'h00b76463, 1'b0, 8'h00, 0, 8'h10, 3, 1'b0, 0, 0, 0, 1'b0};
    tbl[7]  = '{1'b0, 32'h0006a803, 1'b0, 8'h00, 3, 8'h14, 8, 1'b0, 1, 4, 0, 1'b1};
    tbl[8]  = '{1'b0, 32'h00b6a023, 1'b0, 8'h00, 0, 8'h18, 4, 1'b0, 0, 0, 1, 1'b1};
    tbl[9]  = '{1'b0, 32'h00b6a023, 1'b0, 8'h00, 2, 8'h1c, 6, 1'b0, 0, 0, 3, 1'b1};
    tbl[10] = '{1'b0, 32'h00408067, 1'b0, 8'hfe, 0, 8'h1c, 0, 1'b1, 0, 0, 0, 1'b1};
    tbl[11] = '{1'b1, 32'h00b76463, 1'b1, 8'h00, 0, 8'h08, 3, 1'b0, 0, 0, 0, 1'b0};
    tbl[12] = '{1'b1, 32'hffffffff, 1'b0, 8'h00, 0, 8'h00, 0, 1'b1, 0, 0, 0, 1'b0};

    // Reset values.
    do_reset();
    chk("rst_pc", 32'(pc), 32'h0);
    chk("rst_ir", ir, 32'h0);
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_outs", 32'({alu_imm, mem_re, mem_we, reg_we, retire, halt}), 32'h0);

    // run=0 holds in FETCH without latching.
    run = 1'b0;
    instr = 32'h00450693;
    repeat (3) @(negedge clk);
    chk("hold_state", 32'(state), 32'd0);
    chk("hold_pc", 32'(pc), 32'h0);
    chk("hold_ir", ir, 32'h0);

    foreach (tbl[i]) begin
      if (tbl[i].do_rst) do_reset();
      exec_one(tbl[i].w, tbl[i].bt, tbl[i].rs1, tbl[i].dly, 1'b0, o);
      chk($sformatf("v%0d_pc", i), 32'(o.npc), 32'(tbl[i].e_pc));
      chk($sformatf("v%0d_halt", i), 32'(o.hlt), 32'(tbl[i].e_hlt));
      chk($sformatf("v%0d_ir", i), ir, tbl[i].w);
      chk($sformatf("v%0d_alu_imm", i), 32'(o.aimm), 32'(tbl[i].e_aimm));
      if (!tbl[i].e_hlt) begin
        chk($sformatf("v%0d_cycles", i), 32'(o.cyc), 32'(tbl[i].e_cyc));
        chk($sformatf("v%0d_reg_we", i), 32'(o.rwe), 32'(tbl[i].e_rwe));
        chk($sformatf("v%0d_mem_re", i), 32'(o.re), 32'(tbl[i].e_re));
        chk($sformatf("v%0d_mem_we", i), 32'(o.we), 32'(tbl[i].e_we));
      end
    end

    // HALT is sticky and quiet.
    run = 1'b1;
    instr = 32'h00450693;
    mem_ack = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    chk("halt_state", 32'(state), 32'd5);
    chk("halt_flag", 32'(halt), 32'd1);
    chk("halt_pc", 32'(pc), 32'h0);
    chk("halt_ir", ir, 32'hffffffff);
    chk("halt_enables", 32'({alu_imm, mem_re, mem_we, reg_we, retire}), 32'h0);
    mem_ack = 1'b0;

    // Reset while a load is waiting in MEM.
    do_reset();
    instr = 32'h0006a803;
    run = 1'b1;
    for (int k = 0; k < 10 && state != 3'd3; k++) @(negedge clk);
    chk("mem_reached", 32'(state), 32'd3);
    chk("mem_re_pending", 32'(mem_re), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mem_re", 32'(mem_re), 32'd0);
    chk("rst_mem_state", 32'(state), 32'd0);
    chk("rst_mem_pc", 32'(pc), 32'h0);

    // Randomized program against the model, with run/mem_ack noise outside their phases.
    do_reset();
    exp_pc = 8'h00;
    for (int n = 0; n < 200; n++) begin
      int cls;
      cls = int'($urandom_range(0, 15));
      w   = $urandom;
      bt  = 1'($urandom);
      rs1 = 8'($urandom);
      dly = int'($urandom_range(0, 3));
      case (cls)
        0, 15: w = 32'h0;
        1: while (legal_opc(w[6:0]) || w == 32'h0) w = $urandom;
        2, 3: w[6:0] = 7'b0010011;
        4: w[6:0] = 7'b0110011;
        5, 6: w[6:0] = 7'b0000011;
        7: w[6:0] = 7'b0100011;
        8, 9: begin w[6:0] = 7'b1100011; w[8] = 1'b0; end
        10: begin w[6:0] = 7'b1101111; w[21] = 1'b0; end
        11: begin w[6:0] = 7'b1100111; w[21] = 1'b0; rs1[1:0] = 2'b00; end
        12: w[6:0] = 7'b1101111;
        13: w[6:0] = 7'b1100111;
        default: w[6:0] = 7'b1100011;
      endcase
      if ($urandom_range(0, 7) == 0) begin
        run = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clk);
        chk("rnd_idle_state", 32'(state), 32'd0);
      end
      e = model(exp_pc, w, bt, rs1, dly);
      exec_one(w, bt, rs1, dly, 1'b1, o);
      chk($sformatf("r%0d_pc", n), 32'(o.npc), 32'(e.npc));
      chk($sformatf("r%0d_halt", n), 32'(o.hlt), 32'(e.hlt));
      chk($sformatf("r%0d_alu_imm", n), 32'(o.aimm), 32'(e.aimm));
      if (!e.hlt) begin
        chk($sformatf("r%0d_cycles", n), 32'(o.cyc), 32'(e.cyc));
        chk($sformatf("r%0d_reg_we", n), 32'(o.rwe), 32'(e.rwe));
        chk($sformatf("r%0d_mem", n), 32'({o.re[15:0], o.we[15:0]}),
            32'({e.re[15:0], e.we[15:0]}));
      end
      exp_pc = e.npc;
      if (e.hlt || halt) begin
        do_reset();
        exp_pc = 8'h00;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
